pipe_reg: RTL and testbench



---
 rtl/pipe_reg.sv | 82 ++++++++
 tb/tb_pipe_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg.sv
// pipe_reg: WIDTH x DEPTH stallable delay line with per-stage
// valid bits, synchronous flush and a registered occupancy count.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   en        1 = shift one stage, 0 = hold
//   flush     clears all valid bits and count (data kept)
//   in_valid  qualifies d
//   d         input word
//   q         stage DEPTH-1 data
//   out_valid stage DEPTH-1 valid
//   taps      all stage data, stage i at [i*WIDTH +: WIDTH]
//   count     number of valid stages, 0..DEPTH
//
// Build option: define PIPE_REG_RESET_DATA_EN to also clear the
// data registers on reset. Left undefined, data has no reset
// so it may map onto shift-register primitives.

module pipe_reg #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = (DEPTH + 1 > 2) ? $clog2(DEPTH + 1) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       d,
  output logic [WIDTH-1:0]       q,
  output logic                   out_valid,
  output logic [WIDTH*DEPTH-1:0] taps,
  output logic [CW-1:0]          count
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [CW-1:0]               count_q, count_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (reset) begin
      valid_d = '0;
      count_d = '0;
`ifdef PIPE_REG_RESET_DATA_EN
      data_d  = '0;
`endif
    end else if (flush) begin
      valid_d = '0;
      count_d = '0;
    end else if (en) begin
      data_d[0]  = d;
      valid_d[0] = in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Modular add/sub: the transient count+1 may wrap, but
      // the net result is always in 0..DEPTH.
      count_d = count_q + CW'(in_valid)
              - CW'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    count_q <= count_d;
  end

  assign q         = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];
  assign taps      = data_q;
  assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed table-driven bench for pipe_reg,
// WIDTH=8 DEPTH=4, plus a hand-written stall/latency sequence.

module tb_pipe_reg;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int CW = 3;

`ifdef PIPE_REG_RESET_DATA_EN
  localparam logic [7:0] RQ = 8'h00;
`else
  localparam logic [7:0] RQ = 8'hA5;
`endif

  logic          clk = 1'b0;
  logic          reset, en, flush, in_valid;
  logic [W-1:0]  d;
  logic [W-1:0]  q;
  logic          out_valid;
  logic [W*D-1:0] taps;
  logic [CW-1:0] count;

  pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .flush(flush),
    .in_valid(in_valid),
    .d(d),
    .q(q),
    .out_valid(out_valid),
    .taps(taps),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fl;
    logic        en;
    logic        iv;
    logic [7:0]  d;
    logic [7:0]  eq;
    logic        eov;
    logic [2:0]  ecnt;
    logic        cq;
    logic        ct;
    logic [31:0] et;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    logic rst, logic fl, logic e, logic iv,
    logic [7:0] dd, logic [7:0] eq, logic eov,
    logic [2:0] ecnt, logic cq,
    logic ct = 1'b0, logic [31:0] et = '0);
    vec_t v;
    v.rst = rst; v.fl = fl; v.en = e; v.iv = iv;
    v.d = dd; v.eq = eq; v.eov = eov; v.ecnt = ecnt;
    v.cq = cq; v.ct = ct; v.et = et;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f,
                       input logic e, input logic iv,
                       input logic [7:0] dd);
    reset = r; flush = f; en = e; in_valid = iv; d = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] tq;
    logic [7:0]  hq;
    reset = 1'b1; flush = 1'b0; en = 1'b0;
    in_valid = 1'b0; d = '0;

    // reset, prefill with A5, reset again with en=1
    tbl.push_back(mk(1,0,0,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(1,0,1,1,8'h99,8'h00,0,0,0));
    tbl.push_back(mk(0,0,1,1,8'hA5,8'h00,0,1,0));
    tbl.push_back(mk(0,0,1,1,8'hA5,8'h00,0,2,0));
    tbl.push_back(mk(0,0,1,1,8'hA5,8'h00,0,3,0));
    tbl.push_back(mk(0,0,1,1,8'hA5,8'hA5,1,4,1,
                     1,32'hA5A5A5A5));
    tbl.push_back(mk(1,0,1,1,8'h77,RQ,0,0,1,
                     1,{4{RQ}}));
    tbl.push_back(mk(1,0,1,1,8'h77,RQ,0,0,1,
                     1,{4{RQ}}));
    // latency and order
    tbl.push_back(mk(0,0,1,1,8'h11,RQ,0,1,1));
    tbl.push_back(mk(0,0,1,1,8'h22,RQ,0,2,1));
    tbl.push_back(mk(0,0,1,1,8'h33,RQ,0,3,1));
    tbl.push_back(mk(0,0,1,1,8'h44,8'h11,1,4,1));
    tbl.push_back(mk(0,0,1,1,8'h55,8'h22,1,4,1,
                     1,32'h22334455));
    // stall while d changes
    tbl.push_back(mk(0,0,0,1,8'hE1,8'h22,1,4,1,
                     1,32'h22334455));
    tbl.push_back(mk(0,0,0,0,8'hE2,8'h22,1,4,1,
                     1,32'h22334455));
    tbl.push_back(mk(0,0,0,1,8'hE3,8'h22,1,4,1,
                     1,32'h22334455));
    tbl.push_back(mk(0,0,1,1,8'h66,8'h33,1,4,1,
                     1,32'h33445566));
    // bubbles
    tbl.push_back(mk(0,0,1,1,8'hB1,8'h44,1,4,1));
    tbl.push_back(mk(0,0,1,0,8'hB2,8'h55,1,3,1));
    tbl.push_back(mk(0,0,1,1,8'hB3,8'h66,1,3,1));
    tbl.push_back(mk(0,0,1,0,8'hB4,8'hB1,1,2,1));
    tbl.push_back(mk(0,0,1,1,8'hB5,8'hB2,0,2,1));
    tbl.push_back(mk(0,0,1,0,8'hB6,8'hB3,1,2,1));
    tbl.push_back(mk(0,0,1,1,8'hB7,8'hB4,0,2,1));
    tbl.push_back(mk(0,0,1,0,8'hB8,8'hB5,1,2,1));
    // refill to full
    tbl.push_back(mk(0,0,1,1,8'hC1,8'hB6,0,2,1));
    tbl.push_back(mk(0,0,1,1,8'hC2,8'hB7,1,3,1));
    tbl.push_back(mk(0,0,1,1,8'hC3,8'hB8,0,3,1));
    tbl.push_back(mk(0,0,1,1,8'hC4,8'hC1,1,4,1,
                     1,32'hC1C2C3C4));
    // flush collides with en and a valid 0x77
    tbl.push_back(mk(0,1,1,1,8'h77,8'hC1,0,0,1,
                     1,32'hC1C2C3C4));
    tbl.push_back(mk(0,0,1,1,8'hD1,8'hC2,0,1,1,
                     1,32'hC2C3C4D1));
    tbl.push_back(mk(0,0,1,0,8'hD2,8'hC3,0,1,1));
    tbl.push_back(mk(0,0,1,0,8'hD3,8'hC4,0,1,1));
    tbl.push_back(mk(0,0,1,0,8'hD4,8'hD1,1,1,1));
    tbl.push_back(mk(0,0,1,0,8'hD5,8'hD2,0,0,1));
    tbl.push_back(mk(0,1,0,0,8'h00,8'hD2,0,0,1));
    // reset mid-stream, resume with no idle cycle
    tbl.push_back(mk(0,0,1,1,8'hE1,8'hD3,0,1,1));
    tbl.push_back(mk(0,0,1,1,8'hE2,8'hD4,0,2,1));
    tbl.push_back(mk(1,0,1,1,8'hFF,8'h00,0,0,0));
    tbl.push_back(mk(0,0,1,1,8'hF1,8'h00,0,1,0));
    tbl.push_back(mk(0,0,1,1,8'hF2,8'h00,0,2,0));
    tbl.push_back(mk(0,0,1,1,8'hF3,8'h00,0,3,0));
    tbl.push_back(mk(0,0,1,1,8'hF4,8'hF1,1,4,1,
                     1,32'hF1F2F3F4));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].fl, tbl[i].en,
            tbl[i].iv, tbl[i].d);
      n_vec++;
      chk("out_valid", i, 32'(out_valid),
          32'(tbl[i].eov));
      chk("count", i, 32'(count), 32'(tbl[i].ecnt));
      if (tbl[i].cq)
        chk("q", i, 32'(q), 32'(tbl[i].eq));
      if (tbl[i].ct)
        chk("taps", i, taps, tbl[i].et);
    end

    // hand sequence: flush, push one word, then
    // alternate stalls; word must emerge after the
    // 4th enabled edge only, stalls freezing outputs
    drive(0, 1, 0, 0, 8'h00);
    n_vec++;
    chk("hs_flush_cnt", 100, 32'(count), 32'd0);
    drive(0, 0, 1, 1, 8'h5E);
    n_vec++;
    chk("hs_push_cnt", 101, 32'(count), 32'd1);
    for (int k = 0; k < 6; k++) begin
      tq = taps;
      hq = q;
      drive(0, 0, (k % 2) == 1, 0, 8'(8'h90 + k));
      n_vec++;
      if ((k % 2) == 0) begin
        chk("hs_stall_taps", 110 + k, taps, tq);
        chk("hs_stall_q", 110 + k, 32'(q), 32'(hq));
      end
      chk("hs_cnt", 110 + k, 32'(count), 32'd1);
      chk("hs_ov", 110 + k, 32'(out_valid),
          32'(k == 5));
    end
    chk("hs_q", 120, 32'(q), 32'h5E);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
